// File: rtl/sixbitmul_seq.sv
// Sequential shift-add 6x6 unsigned multiplier with start/busy/done handshake.
// Optional macro SIXBITMUL_SEQ_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module sixbitmul_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] ain,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [5:0] prod,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  a_q, a_d;
    logic [5:0]  b_q, b_d;
    logic [11:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  prod_q, prod_d;
    logic        ovf_q, ovf_d;

    logic [5:0]  b_shift_s;
    logic [11:0] addend_s;
    logic [11:0] sum_s;
    logic        last_s;

    // Partial-product datapath and termination test for the current bit
    always_comb begin
        b_shift_s = b_q >> cnt_q;
        if (b_shift_s[0]) begin
            addend_s = {6'd0, a_q} << cnt_q;
        end else begin
            addend_s = 12'd0;
        end
        sum_s = acc_q + addend_s;
`ifdef SIXBITMUL_SEQ_EARLY_EXIT_EN
        last_s = (b_shift_s[5:1] == 5'd0);
`else
        last_s = (cnt_q == 3'd5);
`endif
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new request directly for back-to-back operation
                if (start) begin
                    a_d     = ain;
                    b_d     = bin;
                    acc_d   = 12'd0;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = sum_s;
                if (last_s) begin
                    cnt_d   = 3'd0;
                    prod_d  = sum_s[5:0];
                    ovf_d   = |sum_s[11:6];
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 6'd0;
            b_q     <= 6'd0;
            acc_q   <= 12'd0;
            cnt_q   <= 3'd0;
            prod_q  <= 6'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign prod     = prod_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sixbitmul_seq.sv
// Directed self-checking bench for sixbitmul_seq; RUN length expectations follow
// SIXBITMUL_SEQ_EARLY_EXIT_EN when the bench is compiled with it.
module tb_sixbitmul_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] ain;
    logic [5:0] bin;
    logic       busy;
    logic       done;
    logic [5:0] prod;
    logic       overflow;

    int n_pass;
    int n_total;

    sixbitmul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ain      (ain),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .prod     (prod),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of RUN cycles for a given multiplier
    function automatic int exp_run(input logic [5:0] b);
`ifdef SIXBITMUL_SEQ_EARLY_EXIT_EN
        int r;
        r = 1;
        for (int k = 0; k < 6; k++) begin
            if (b[k]) r = k + 1;
        end
        return r;
`else
        return 6;
`endif
    endfunction

    // Issue one request, count busy cycles, capture outputs in the done cycle
    task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                          output int run_cyc, output logic got_done,
                          output logic [5:0] p, output logic o);
        @(negedge clk);
        start = 1'b1;
        ain   = a;
        bin   = b;
        @(negedge clk);
        start = 1'b0;
        run_cyc = 0;
        while (busy === 1'b1 && run_cyc < 20) begin
            run_cyc++;
            @(negedge clk);
        end
        got_done = done;
        p        = prod;
        o        = overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        ain   = 6'd7;
        bin   = 6'd7;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, prod, overflow} !== 9'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b prod=%h ovf=%b, want all 0",
                     busy, done, prod, overflow);
        end else n_pass++;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_wins_start: got busy=%b, want 0", busy);
        end else n_pass++;
    endtask

    task automatic test_basic();
        int r;
        logic d, o;
        logic [5:0] p;
        run_op(6'd7, 6'd5, r, d, p, o);
        n_total++;
        if (r !== exp_run(6'd5)) begin
            $display("FAIL basic_busy_len: got %0d, want %0d", r, exp_run(6'd5));
        end else n_pass++;
        n_total++;
        if ({d, p, o} !== {1'b1, 6'h23, 1'b0}) begin
            $display("FAIL basic_7x5: got done=%b prod=%h ovf=%b, want 1 23 0", d, p, o);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done, prod} !== {1'b0, 6'h23}) begin
            $display("FAIL done_one_cycle_hold: got done=%b prod=%h, want 0 23", done, prod);
        end else n_pass++;
    endtask

    task automatic test_boundary();
        logic [5:0] av [4] = '{6'd63, 6'd8, 6'd0, 6'd5};
        logic [5:0] bv [4] = '{6'd63, 6'd8, 6'd5, 6'd0};
        logic [5:0] pv [4] = '{6'h01, 6'h00, 6'h00, 6'h00};
        logic       ov [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int r;
        logic d, o;
        logic [5:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], r, d, p, o);
            n_total++;
            if ({d, p, o} !== {1'b1, pv[i], ov[i]}) begin
                $display("FAIL boundary_%0dx%0d: got done=%b prod=%h ovf=%b, want 1 %h %b",
                         av[i], bv[i], d, p, o, pv[i], ov[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [5:0] bv [4] = '{6'd0, 6'd1, 6'h04, 6'h20};
        logic [5:0] pv [4] = '{6'h00, 6'h05, 6'h14, 6'h20};
        logic       ov [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int r;
        logic d, o;
        logic [5:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(6'd5, bv[i], r, d, p, o);
            n_total++;
            if (r !== exp_run(bv[i]) || {d, p, o} !== {1'b1, pv[i], ov[i]}) begin
                $display("FAIL latency_5x%h: got run=%0d done=%b prod=%h ovf=%b, want %0d 1 %h %b",
                         bv[i], r, d, p, o, exp_run(bv[i]), pv[i], ov[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int first_i;
        int second_i;
        first_i  = -1;
        second_i = -1;
        @(negedge clk);
        start = 1'b1;
        ain   = 6'd11;
        bin   = 6'd13;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first_i < 0) begin
                    first_i = i;
                    n_total++;
                    if ({prod, overflow} !== {6'h0F, 1'b1}) begin
                        $display("FAIL b2b_first_11x13: got prod=%h ovf=%b, want 0f 1", prod, overflow);
                    end else n_pass++;
                    ain = 6'd3;
                    bin = 6'd6;
                end else if (second_i < 0) begin
                    second_i = i;
                    start = 1'b0;
                    n_total++;
                    if ({prod, overflow} !== {6'd18, 1'b0}) begin
                        $display("FAIL b2b_second_3x6: got prod=%h ovf=%b, want 12 0", prod, overflow);
                    end else n_pass++;
                end
            end else begin
                ain = 6'(i * 7 + 1);
                bin = 6'(i * 5 + 2);
            end
        end
        n_total++;
        if (first_i < 0 || second_i < 0 || (second_i - first_i) !== exp_run(6'd6) + 1) begin
            $display("FAIL b2b_spacing: got first=%0d second=%0d, want spacing %0d",
                     first_i, second_i, exp_run(6'd6) + 1);
        end else n_pass++;
        n_total++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL b2b_no_third: got busy=%b done=%b, want 0 0", busy, done);
        end else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int r;
        int seen_done;
        logic d, o;
        logic [5:0] p;
        @(negedge clk);
        start = 1'b1;
        ain   = 6'd9;
        bin   = 6'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done, prod, overflow} !== 9'd0) begin
            $display("FAIL midrun_reset: got busy=%b done=%b prod=%h ovf=%b, want all 0",
                     busy, done, prod, overflow);
        end else n_pass++;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_total++;
        if (seen_done !== 0) begin
            $display("FAIL midrun_no_done: got %0d active cycles, want 0", seen_done);
        end else n_pass++;
        run_op(6'd3, 6'd4, r, d, p, o);
        n_total++;
        if ({d, p, o} !== {1'b1, 6'd12, 1'b0}) begin
            $display("FAIL after_reset_3x4: got done=%b prod=%h ovf=%b, want 1 0c 0", d, p, o);
        end else n_pass++;
    endtask

    task automatic test_sweep();
        int r;
        int e;
        logic d, o;
        logic [5:0] p;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                run_op(6'(a), 6'(b), r, d, p, o);
                e = a * b;
                n_total++;
                if (d !== 1'b1 || p !== e[5:0] || o !== (e > 63) || r !== exp_run(6'(b))) begin
                    $display("FAIL sweep_%0dx%0d: got done=%b prod=%h ovf=%b run=%0d, want 1 %h %b %0d",
                             a, b, d, p, o, r, e[5:0], (e > 63), exp_run(6'(b)));
                end else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_latency();
        test_back_to_back();
        test_reset_midrun();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
